// File: rtl/data_mem_responder.sv
// data_mem_responder: word memory slave with fixed wait-state latency and error response
module data_mem_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           wd;
  logic                  wr_q, err_q, req_err;
  logic [31:0]           mem [2**DEPTH_LOG2];
  assign req_err = (address[1:0] != 2'b00) || ((address >> (DEPTH_LOG2 + 2)) != '0) || (mem_rd && mem_wr);
  assign busy = state != IDLE;
  // RESP is the cycle before the strobe; outputs are registered as RESP is left
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      wd        <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data   <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: if (mem_rd || mem_wr) begin
          idx   <= address[DEPTH_LOG2+1:2];
          wd    <= wdata;
          wr_q  <= mem_wr;
          err_q <= req_err;
          cnt   <= LAT;
          state <= (LAT == 4'd0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= (cnt == 4'd1) ? RESP : WAIT;
        end
        RESP: begin
          mem_ready <= 1'b1;
          mem_err   <= err_q;
          rd_data   <= (err_q || wr_q) ? '0 : mem[idx];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (state == RESP && wr_q && !err_q) mem[idx] <= wd;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  logic [31:0] addr_a = 0, wd_a = 0, addr_b = 0, wd_b = 0;
  logic [31:0] data_a, data_b, data_s;
  logic        rdy_a, err_a, busy_a, rdy_b, err_b, busy_b, rdy_s, err_s, busy_s;
  bit          sel = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2), .DEPTH_LOG2(6)) dut_a (
    .clk(clk), .rst(rst), .mem_rd(rd_a), .mem_wr(wr_a), .address(addr_a), .wdata(wd_a),
    .rd_data(data_a), .mem_ready(rdy_a), .mem_err(err_a), .busy(busy_a));

  data_mem_responder #(.LATENCY(0), .DEPTH_LOG2(6)) dut_b (
    .clk(clk), .rst(rst), .mem_rd(rd_b), .mem_wr(wr_b), .address(addr_b), .wdata(wd_b),
    .rd_data(data_b), .mem_ready(rdy_b), .mem_err(err_b), .busy(busy_b));

  assign data_s = sel ? data_b : data_a;
  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign err_s  = sel ? err_b  : err_a;
  assign busy_s = sel ? busy_b : busy_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      rd_b = r; wr_b = w; addr_b = a; wd_b = wd;
    end else begin
      rd_a = r; wr_a = w; addr_a = a; wd_a = wd;
    end
  endtask

  // one request held for exactly the acceptance edge, then the response is timed and checked
  task automatic xfer(input bit d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    int n;
    sel = d;
    drive(d, r, w, a, wd);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    check({tag, "_busy"}, 32'(busy_s), 32'd1);
    n = 0;
    while (!rdy_s && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), d ? 32'd1 : 32'd3);
    check({tag, "_data"}, data_s, exp_d);
    check({tag, "_err"}, 32'(err_s), 32'(exp_e));
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, {30'd0, rdy_s, err_s}, 32'd0);
    check({tag, "_idle"}, 32'(busy_s), 32'd0);
    check({tag, "_hold"}, data_s, exp_d);
  endtask

  initial begin
    int cnt;
    #3;
    check("reset_a", {data_a[30:0], rdy_a, err_a, busy_a} | {3'd0, data_a[31:3]}, 34'd0 == 0 ? 32'd0 : 32'd1);
    check("reset_b", {rdy_b, err_b, busy_b} | data_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    xfer(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, "wr10");
    xfer(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "rd10");
    xfer(0, 1, 0, 32'h13, 32'h0, 32'h0, 1, "rd13_misaligned");
    xfer(0, 1, 0, 32'h100, 32'h0, 32'h0, 1, "rd100_range");
    xfer(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "rd10_again");
    xfer(0, 0, 1, 32'h20, 32'h11111111, 32'h0, 0, "wr20");
    xfer(0, 1, 1, 32'h20, 32'h12345678, 32'h0, 1, "rdwr20");
    xfer(0, 1, 0, 32'h20, 32'h0, 32'h11111111, 0, "rd20");

    // second request toggled while the first is waiting
    sel = 0;
    drive(0, 0, 1, 32'h08, 32'h0BADF00D);
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h0C, 32'h0);
    check("toggle_busy1", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 32'h0, 32'h0);
    check("toggle_busy2", 32'(busy_a), 32'd1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy_a) cnt++;
    end
    check("toggle_one_ready", 32'(cnt), 32'd1);
    xfer(0, 1, 0, 32'h08, 32'h0, 32'h0BADF00D, 0, "rd08");

    // reset pulsed in the middle of a write
    xfer(0, 0, 1, 32'h04, 32'h77777777, 32'h0, 0, "wr04");
    xfer(0, 1, 0, 32'h04, 32'h0, 32'h77777777, 0, "rd04");
    drive(0, 0, 1, 32'h04, 32'hA5A5A5A5);
    @(posedge clk); #1;
    drive(0, 0, 0, 32'h0, 32'h0);
    check("abort_busy", 32'(busy_a), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_data", data_a, 32'h0);
    check("abort_flags", {29'd0, rdy_a, err_a, busy_a}, 32'd0);
    #2 rst = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy_a) cnt++;
    end
    check("abort_no_ready", 32'(cnt), 32'd0);
    xfer(0, 1, 0, 32'h04, 32'h0, 32'h77777777, 0, "rd04_kept");

    xfer(1, 0, 1, 32'h00, 32'hCAFEF00D, 32'h0, 0, "b_wr00");
    xfer(1, 0, 1, 32'hFC, 32'h0F0F0F0F, 32'h0, 0, "b_wrFC");
    xfer(1, 1, 0, 32'h00, 32'h0, 32'hCAFEF00D, 0, "b_rd00");
    xfer(1, 1, 0, 32'hFC, 32'h0, 32'h0F0F0F0F, 0, "b_rdFC");
    xfer(1, 1, 0, 32'h100, 32'h0, 32'h0, 1, "b_rd100");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
